// File: rtl/circle_pkg.sv
// Shared types and constants for the circle drawing engine.
package circle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OCT  = 2'd1,
        ST_SPAN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int         OCT_STEPS = 8;
    localparam logic [2:0] LAST_STEP = 3'(OCT_STEPS - 1);

endpackage

// File: rtl/circle_engine_if.sv
// Draw request and pixel-write bus between a requester and circle_engine.
interface circle_engine_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) ();

    logic                start;
    logic [COLOUR_W-1:0] colour;
    logic [X_W-1:0]      centre_x;
    logic [Y_W-1:0]      centre_y;
    logic [X_W-1:0]      radius;
    logic                fill;
    logic [7:0]          octant_mask;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        output start, colour, centre_x, centre_y, radius, fill, octant_mask,
        input  done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, colour, centre_x, centre_y, radius, fill, octant_mask,
        output done, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/circle_engine_stepper.sv
// Midpoint circle stepper: holds ox/oy/crit and exposes the post-iteration values.
module bresenham_stepper #(
    parameter int W   = 10,
    parameter int R_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                advance,
    input  logic [R_W-1:0]      radius,
    output logic signed [W-1:0] ox,
    output logic signed [W-1:0] oy,
    output logic signed [W-1:0] ox_nxt,
    output logic signed [W-1:0] oy_nxt,
    output logic                more
);

    localparam logic signed [W-1:0] ZERO = {W{1'b0}};
    localparam logic signed [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    logic signed [W-1:0] ox_q, ox_d, oy_q, oy_d, crit_q, crit_d;
    logic signed [W-1:0] oy_inc, ox_adv, crit_adv, rad_ext;

    assign rad_ext = {{(W-R_W){1'b0}}, radius};

    // Decision-variable update using the already-incremented oy and ox.
    always_comb begin
        oy_inc = oy_q + ONE;
        if (crit_q <= ZERO) begin
            ox_adv   = ox_q;
            crit_adv = crit_q + oy_inc + oy_inc + ONE;
        end else begin
            ox_adv   = ox_q - ONE;
            crit_adv = crit_q + (oy_inc - ox_adv) + (oy_inc - ox_adv) + ONE;
        end
    end

    // Select load, advance or hold for the stepper registers.
    always_comb begin
        ox_d   = ox_q;
        oy_d   = oy_q;
        crit_d = crit_q;
        if (load) begin
            ox_d   = rad_ext;
            oy_d   = ZERO;
            crit_d = ONE - rad_ext;
        end else if (advance) begin
            ox_d   = ox_adv;
            oy_d   = oy_inc;
            crit_d = crit_adv;
        end else begin
            ox_d   = ox_q;
            oy_d   = oy_q;
            crit_d = crit_q;
        end
    end

    // Stepper state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ox_q   <= ZERO;
            oy_q   <= ZERO;
            crit_q <= ZERO;
        end else begin
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            crit_q <= crit_d;
        end
    end

    assign ox     = ox_q;
    assign oy     = oy_q;
    assign ox_nxt = ox_adv;
    assign oy_nxt = oy_inc;
    assign more   = (oy_inc <= ox_adv);

endmodule

// File: rtl/circle_engine.sv
// Circle engine: plots an octant-masked outline or a filled disc, one pixel per cycle.
module circle_engine
    import circle_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic          clk,
    input  logic          rst_n,
    circle_engine_if.slave bus
);

    localparam int W = X_W + 2;
    localparam logic signed [W-1:0] ZERO  = {W{1'b0}};
    localparam logic signed [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};
    localparam logic signed [W-1:0] LIM_X = W'(SCREEN_W);
    localparam logic signed [W-1:0] LIM_Y = W'(SCREEN_H);

    state_e              state_q, state_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic signed [W-1:0] cx_q, cx_d, cy_q, cy_d, xi_q, xi_d;
    logic [7:0]          mask_q, mask_d;
    logic [2:0]          step_q, step_d;
    logic [1:0]          span_q, span_d;

    logic [X_W-1:0]      vga_x_q, vga_x_d;
    logic [Y_W-1:0]      vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
    logic                vga_plot_q, vga_plot_d, done_q, done_d;

    logic signed [W-1:0] ox, oy, ox_nxt, oy_nxt, half, px, py;
    logic                more, st_load, span_end, iter_end, en, on_screen;

    assign st_load  = (state_q == ST_IDLE) && bus.start;
    // Spans 0/1 run over +-ox, spans 2/3 over +-oy.
    assign half     = (span_q[1] == 1'b0) ? ox : oy;
    assign span_end = (xi_q == half);
    assign iter_end = ((state_q == ST_OCT)  && (step_q == LAST_STEP)) ||
                      ((state_q == ST_SPAN) && (span_q == 2'd3) && span_end);

    bresenham_stepper #(.W(W), .R_W(X_W)) u_stepper (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (st_load),
        .advance (iter_end),
        .radius  (bus.radius),
        .ox      (ox),
        .oy      (oy),
        .ox_nxt  (ox_nxt),
        .oy_nxt  (oy_nxt),
        .more    (more)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = bus.fill ? ST_SPAN : ST_OCT;
                else           state_d = ST_IDLE;
            end
            ST_OCT, ST_SPAN: begin
                if (iter_end && !more) state_d = ST_DONE;
                else                   state_d = state_q;
            end
            ST_DONE: begin
                if (!bus.start) state_d = ST_IDLE;
                else            state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latching and step/span/x counters.
    always_comb begin
        colour_d = colour_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        mask_d   = mask_q;
        step_d   = step_q;
        span_d   = span_q;
        xi_d     = xi_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    colour_d = bus.colour;
                    cx_d     = {{(W-X_W){1'b0}}, bus.centre_x};
                    cy_d     = {{(W-Y_W){1'b0}}, bus.centre_y};
                    mask_d   = bus.octant_mask;
                    step_d   = 3'd0;
                    span_d   = 2'd0;
                    xi_d     = ZERO - {{(W-X_W){1'b0}}, bus.radius};
                end else begin
                    step_d = step_q;
                end
            end
            ST_OCT: step_d = step_q + 3'd1;
            ST_SPAN: begin
                if (span_end) begin
                    span_d = span_q + 2'd1;
                    case (span_q)
                        2'd0:    xi_d = ZERO - ox;
                        2'd1:    xi_d = ZERO - oy;
                        2'd2:    xi_d = ZERO - oy;
                        default: xi_d = ZERO - ox_nxt;
                    endcase
                end else begin
                    xi_d = xi_q + ONE;
                end
            end
            default: step_d = step_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colour_q <= {COLOUR_W{1'b0}};
            cx_q     <= ZERO;
            cy_q     <= ZERO;
            mask_q   <= 8'h00;
            step_q   <= 3'd0;
            span_q   <= 2'd0;
            xi_q     <= ZERO;
        end else begin
            colour_q <= colour_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            mask_q   <= mask_d;
            step_q   <= step_d;
            span_q   <= span_d;
            xi_q     <= xi_d;
        end
    end

    // FSM outputs: current pixel, clipping and done flag.
    always_comb begin
        px = cx_q;
        py = cy_q;
        en = 1'b0;
        case (state_q)
            ST_OCT: begin
                en = mask_q[step_q];
                case (step_q)
                    3'd0:    begin px = cx_q + ox; py = cy_q + oy; end
                    3'd1:    begin px = cx_q + oy; py = cy_q + ox; end
                    3'd2:    begin px = cx_q - ox; py = cy_q + oy; end
                    3'd3:    begin px = cx_q - oy; py = cy_q + ox; end
                    3'd4:    begin px = cx_q - ox; py = cy_q - oy; end
                    3'd5:    begin px = cx_q - oy; py = cy_q - ox; end
                    3'd6:    begin px = cx_q + ox; py = cy_q - oy; end
                    default: begin px = cx_q + oy; py = cy_q - ox; end
                endcase
            end
            ST_SPAN: begin
                en = 1'b1;
                px = cx_q + xi_q;
                case (span_q)
                    2'd0:    py = cy_q + oy;
                    2'd1:    py = cy_q - oy;
                    2'd2:    py = cy_q + ox;
                    default: py = cy_q - ox;
                endcase
            end
            default: en = 1'b0;
        endcase
        on_screen  = (px >= ZERO) && (px < LIM_X) && (py >= ZERO) && (py < LIM_Y);
        vga_plot_d = en && on_screen;
        if (en) begin
            vga_x_d      = px[X_W-1:0];
            vga_y_d      = py[Y_W-1:0];
            vga_colour_d = colour_q;
        end else begin
            vga_x_d      = vga_x_q;
            vga_y_d      = vga_y_q;
            vga_colour_d = vga_colour_q;
        end
        done_d = (state_d == ST_DONE);
    end

    // Registered pixel-write and done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_x_q      <= {X_W{1'b0}};
            vga_y_q      <= {Y_W{1'b0}};
            vga_colour_q <= {COLOUR_W{1'b0}};
            vga_plot_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            done_q       <= done_d;
        end
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_circle_engine.sv
// Directed bench for circle_engine: per-cycle comparison against a midpoint-circle model.
module tb_circle_engine;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    circle_engine_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(CW)) bus ();

    circle_engine #(
        .X_W(X_W), .Y_W(Y_W), .COLOUR_W(CW), .SCREEN_W(160), .SCREEN_H(120)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int x;
        int y;
        bit plot;
    } pix_t;

    pix_t exp_q[$];
    pix_t got_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic void push_pt(input int x, input int y, input bit en);
        pix_t p;
        p.x    = x;
        p.y    = y;
        p.plot = en && (x >= 0) && (x < 160) && (y >= 0) && (y < 120);
        exp_q.push_back(p);
    endfunction

    // Expected per-cycle pixel stream straight from the midpoint-circle rules.
    function automatic void build_model(input int cx, input int cy, input int r,
                                        input bit fl, input bit [7:0] m);
        int ox, oy, crit;
        int qx[8];
        int qy[8];
        exp_q.delete();
        ox = r; oy = 0; crit = 1 - r;
        do begin
            if (!fl) begin
                qx = '{cx+ox, cx+oy, cx-ox, cx-oy, cx-ox, cx-oy, cx+ox, cx+oy};
                qy = '{cy+oy, cy+ox, cy+oy, cy+ox, cy-oy, cy-ox, cy-oy, cy-ox};
                for (int i = 0; i < 8; i++) push_pt(qx[i], qy[i], m[i]);
            end else begin
                for (int x = cx - ox; x <= cx + ox; x++) push_pt(x, cy + oy, 1'b1);
                for (int x = cx - ox; x <= cx + ox; x++) push_pt(x, cy - oy, 1'b1);
                for (int x = cx - oy; x <= cx + oy; x++) push_pt(x, cy + ox, 1'b1);
                for (int x = cx - oy; x <= cx + oy; x++) push_pt(x, cy - ox, 1'b1);
            end
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endfunction

    // Compare process: start already presented; checks every output cycle of one draw.
    task automatic check_draw(input int col);
        int   n;
        pix_t g;
        n = exp_q.size();
        got_q.delete();
        @(posedge clk);
        #1;
        bus.centre_x    = bus.centre_x ^ 8'h5A;
        bus.centre_y    = bus.centre_y ^ 7'h15;
        bus.radius      = bus.radius ^ 8'h33;
        bus.fill        = ~bus.fill;
        bus.octant_mask = ~bus.octant_mask;
        bus.colour      = ~bus.colour;
        @(negedge clk);
        chk("plot_at_launch", int'(bus.vga_plot), 0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            g.x = int'(bus.vga_x);
            g.y = int'(bus.vga_y);
            g.plot = bus.vga_plot;
            got_q.push_back(g);
            chk($sformatf("plot[%0d]", k), int'(g.plot), int'(exp_q[k].plot));
            if (exp_q[k].plot) begin
                chk($sformatf("x[%0d]", k), g.x, exp_q[k].x);
                chk($sformatf("y[%0d]", k), g.y, exp_q[k].y);
                chk($sformatf("colour[%0d]", k), int'(bus.vga_colour), col);
            end
            chk($sformatf("done[%0d]", k), int'(bus.done), (k == n - 1) ? 1 : 0);
        end
        @(negedge clk);
        chk("done_hold", int'(bus.done), 1);
        chk("plot_in_done", int'(bus.vga_plot), 0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_release", int'(bus.done), 0);
    endtask

    task automatic present(input int cx, input int cy, input int r, input bit fl,
                           input bit [7:0] m, input int col);
        bus.centre_x    = 8'(cx);
        bus.centre_y    = 7'(cy);
        bus.radius      = 8'(r);
        bus.fill        = fl;
        bus.octant_mask = m;
        bus.colour      = 3'(col);
        bus.start       = 1'b1;
    endtask

    task automatic run_draw(input int cx, input int cy, input int r, input bit fl,
                            input bit [7:0] m, input int col);
        build_model(cx, cy, r, fl, m);
        @(negedge clk);
        present(cx, cy, r, fl, m, col);
        check_draw(col);
    endtask

    initial begin
        int lx[8];
        int ly[8];
        int cnt, viol, found, dx, dy, adx, ady;
        lx = '{120, 80, 40, 80, 40, 80, 120, 80};
        ly = '{60, 100, 60, 100, 60, 20, 60, 20};

        rst_n = 1'b0;
        present(0, 0, 0, 1'b0, 8'h00, 0);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_plot", int'(bus.vga_plot), 0);
        chk("rst_x", int'(bus.vga_x), 0);
        chk("rst_y", int'(bus.vga_y), 0);
        chk("rst_colour", int'(bus.vga_colour), 0);
        rst_n = 1'b1;

        // r=0: one iteration, eight plots at the centre
        run_draw(80, 60, 0, 1'b0, 8'hFF, 5);
        chk("r0_model_len", exp_q.size(), 8);
        cnt = 0;
        foreach (got_q[i]) if (got_q[i].plot && got_q[i].x == 80 && got_q[i].y == 60) cnt++;
        chk("r0_centre_plots", cnt, 8);

        // r=40: first iteration pinned to hand-computed points
        run_draw(80, 60, 40, 1'b0, 8'hFF, 3);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("r40_x%0d", i), got_q[i].x, lx[i]);
            chk($sformatf("r40_y%0d", i), got_q[i].y, ly[i]);
        end

        // clipping at the origin: same cycle budget, off-screen steps silent
        run_draw(0, 0, 10, 1'b0, 8'hFF, 7);

        // only octant 0 enabled: 4 iterations, all plots in the lower-right quadrant
        run_draw(80, 60, 5, 1'b0, 8'h01, 1);
        cnt = 0; viol = 0;
        foreach (got_q[i]) if (got_q[i].plot) begin
            cnt++;
            if (got_q[i].x < 80 || got_q[i].y < 60) viol++;
        end
        chk("mask01_plots", cnt, 4);
        chk("mask01_quadrant", viol, 0);

        // filled r=2 disc
        run_draw(80, 60, 2, 1'b1, 8'h00, 4);
        chk("fill_r2_model_len", exp_q.size(), 28);
        for (int ddy = -2; ddy <= 2; ddy++)
            for (int ddx = -2; ddx <= 2; ddx++)
                if (ddx * ddx + ddy * ddy <= 4) begin
                    found = 0;
                    foreach (got_q[i])
                        if (got_q[i].plot && got_q[i].x == 80 + ddx && got_q[i].y == 60 + ddy) found = 1;
                    chk($sformatf("fill_cover_%0d_%0d", ddx, ddy), found, 1);
                end
        viol = 0;
        foreach (got_q[i]) if (got_q[i].plot) begin
            dx = got_q[i].x - 80; dy = got_q[i].y - 60;
            adx = (dx < 0) ? -dx : dx; ady = (dy < 0) ? -dy : dy;
            if (!((ady <= 1 && adx <= 2) || (ady == 2 && adx <= 1))) viol++;
        end
        chk("fill_outside", viol, 0);

        // clipped fill and clipped masked outline
        run_draw(157, 2, 6, 1'b1, 8'h00, 6);
        run_draw(150, 110, 40, 1'b0, 8'hA5, 2);

        // reset mid-draw, then a held start redraws from the first pixel
        @(negedge clk);
        present(80, 60, 40, 1'b0, 8'hFF, 2);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_plot", int'(bus.vga_plot), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_x", int'(bus.vga_x), 0);
        chk("midrst_y", int'(bus.vga_y), 0);
        chk("midrst_colour", int'(bus.vga_colour), 0);
        @(negedge clk);
        rst_n = 1'b1;
        build_model(80, 60, 40, 1'b0, 8'hFF);
        check_draw(2);
        chk("redraw_x0", got_q[0].x, 120);
        chk("redraw_y0", got_q[0].y, 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/circle_engine.md
CIRCLE_ENGINE -- requirements
Module: circle_engine

Interface
REQ-001 SHALL have parameter X_W, default 8, x coordinate width.
REQ-002 SHALL have parameter Y_W, default 7, y coordinate width.
REQ-003 SHALL have parameter COLOUR_W, default 3, colour width.
REQ-004 SHALL have parameter SCREEN_W, default 160, visible columns.
REQ-005 SHALL have parameter SCREEN_H, default 120, visible rows.
REQ-006 SHALL have port clk, input, 1, single clock for all logic.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, level request to draw.
REQ-009 SHALL have port colour, input, COLOUR_W, draw colour.
REQ-010 SHALL have port centre_x, input, X_W, centre column.
REQ-011 SHALL have port centre_y, input, Y_W, centre row.
REQ-012 SHALL have port radius, input, X_W, radius in pixels.
REQ-013 SHALL have port fill, input, 1, 0 = outline, 1 = filled disc.
REQ-014 SHALL have port octant_mask, input, 8, per-octant enable, outline mode only.
REQ-015 SHALL have port done, output, 1, draw complete.
REQ-016 SHALL have ports vga_x (X_W), vga_y (Y_W), vga_colour (COLOUR_W), vga_plot (1), outputs, pixel write.

Function
REQ-017 SHALL implement states IDLE, OCT, SPAN, DONE.
REQ-018 SHALL, in IDLE with start=1 at a rising edge, latch all inputs and enter OCT (fill=0) or SPAN (fill=1); inputs later ignored until IDLE.
REQ-019 SHALL initialise oy=0, ox=radius, crit=1-radius, all arithmetic signed X_W+2 bits.
REQ-020 SHALL, in OCT, spend exactly 8 cycles per iteration, step i=0..7 at (cx+ox,cy+oy),(cx+oy,cy+ox),(cx-ox,cy+oy),(cx-oy,cy+ox),(cx-ox,cy-oy),(cx-oy,cy-ox),(cx+ox,cy-oy),(cx+oy,cy-ox).
REQ-021 SHALL assert vga_plot for step i only if octant_mask[i]=1 and the point is on-screen; masked or clipped steps still consume their cycle.
REQ-022 SHALL, in SPAN, per iteration emit horizontal spans on rows cy+oy, cy-oy (x from cx-ox to cx+ox) then cy+ox, cy-ox (x from cx-oy to cx+oy), one pixel per cycle; duplicate rows allowed.
REQ-023 SHALL treat a pixel as on-screen iff 0<=x<SCREEN_W and 0<=y<SCREEN_H; off-screen pixels have vga_plot=0.
REQ-024 SHALL, after each iteration, oy=oy+1; if crit<=0 then crit+=2*oy+1, else ox=ox-1 and crit+=2*(oy-ox)+1 (updated values).
REQ-025 SHALL continue while oy<=ox, then enter DONE.
REQ-026 SHALL register vga_x, vga_y, vga_colour, vga_plot; first pixel appears the cycle after start is sampled.
REQ-027 SHALL hold done=1, vga_plot=0 in DONE until start=0, then return to IDLE; done=0 in all other states.
REQ-028 SHALL handle radius=0 as one iteration at the centre.

Reset
REQ-029 SHALL, on rst_n=0 at any time including mid-draw, enter IDLE immediately with done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-030 SHALL require a fresh start after reset release; a held start begins a new draw.

Structure
REQ-031 SHALL place the state enum and octant step count constant in package circle_pkg.
REQ-032 SHALL isolate the ox/oy/crit update in sub-module bresenham_stepper.

Verification
REQ-033 Outline r=0 at (80,60), mask FF -> 8 plots at (80,60), then done=1.
REQ-034 Outline r=40 at (80,60), mask FF -> first 8 pixels (120,60),(80,100),(40,60),(80,100),(40,60),(80,20),(120,60),(80,20); total cycles = 8 x iterations.
REQ-035 Outline r=10 at (0,0), mask FF -> no plot with x or y off-screen, same cycle count as on-screen case.
REQ-036 Outline r=5 at (80,60), mask 01 -> only step-0 pixels plotted, all in x>=80,y>=60.
REQ-037 Fill r=2 at (80,60) -> every pixel within distance 2 of centre plotted, none outside r=2 Bresenham outline.
REQ-038 Assert rst_n=0 mid-draw of r=40 -> next cycle vga_plot=0, done=0; later start redraws from first pixel.
